// File: rtl/pad_seq_ctrl.sv
// pad_seq_ctrl
//   Owns a project's test-pad resource and applies pad changes requested
//   through single-word commands on a valid/ready handshake.
//
//   Ports
//     clk         : single clock, all state on the rising edge
//     rst         : synchronous, active-high reset
//     cmd_valid   : command present
//     cmd_ready   : block can accept a command (high while idle)
//     cmd_op      : 0=SET_OUT, 1=SET_DIR, 2=SET_CFG, 3=SAMPLE
//     cmd_data    : 18-bit operand, low bits used per op
//     done        : one-cycle pulse when a command completes
//     busy        : SET_CFG tristate sequence in progress
//     pad_in      : raw asynchronous pad inputs
//     pad_out     : pad output values
//     pad_dir     : pad direction, 1 = output driven
//     pad_config  : pad configuration word
//     in_sync     : last sampled, synchronized pad_in
//
//   Build option
//     PAD_SEQ_SAFE_CFG_EN : when defined, SET_CFG runs a glitch-safe sequence
//       (tristate, settle, apply config, settle, restore direction). When
//       undefined, SET_CFG applies the config word immediately like the other
//       simple ops and the settle states and counter are not built.
module pad_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [17:0] cmd_data,
  output logic        done,
  output logic        busy,
  input  logic [3:0]  pad_in,
  output logic [1:0]  pad_out,
  output logic [3:0]  pad_dir,
  output logic [17:0] pad_config,
  output logic [3:0]  in_sync
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("pad_seq_ctrl: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [1:0] OP_SET_OUT = 2'd0;
  localparam logic [1:0] OP_SET_DIR = 2'd1;
  localparam logic [1:0] OP_SET_CFG = 2'd2;

  logic [3:0]  sync1_q;
  logic [3:0]  sync2_q;
  logic [1:0]  pad_out_q;
  logic [3:0]  pad_dir_q;
  logic [17:0] pad_config_q;
  logic [3:0]  in_sync_q;
  logic        done_q;
  logic        accept;

`ifdef PAD_SEQ_SAFE_CFG_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_WAIT2 = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [17:0] cfg_pend_q;
  // Direction requested by SET_DIR; restored after the tristate window.
  logic [3:0]  dir_saved_q;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
`else
  assign cmd_ready = 1'b1;
  assign busy      = 1'b0;
`endif

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      pad_out_q    <= '0;
      pad_dir_q    <= '0;
      pad_config_q <= '0;
      in_sync_q    <= '0;
      done_q       <= 1'b0;
`ifdef PAD_SEQ_SAFE_CFG_EN
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dir_saved_q  <= '0;
`endif
    end else begin
      // Two-flop synchronizer runs continuously; SAMPLE only snapshots it.
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
      done_q  <= 1'b0;

      if (accept) begin
        case (cmd_op)
          OP_SET_OUT: begin
            pad_out_q <= cmd_data[1:0];
            done_q    <= 1'b1;
          end
          OP_SET_DIR: begin
            pad_dir_q   <= cmd_data[3:0];
`ifdef PAD_SEQ_SAFE_CFG_EN
            dir_saved_q <= cmd_data[3:0];
`endif
            done_q      <= 1'b1;
          end
          OP_SET_CFG: begin
`ifdef PAD_SEQ_SAFE_CFG_EN
            // Tristate all pads first; the new config lands after one settle
            // period with nothing driven.
            cfg_pend_q <= cmd_data;
            pad_dir_q  <= '0;
            cnt_q      <= SETTLE_M1;
            state_q    <= ST_WAIT1;
`else
            pad_config_q <= cmd_data;
            done_q       <= 1'b1;
`endif
          end
          default: begin
            in_sync_q <= sync2_q;
            done_q    <= 1'b1;
          end
        endcase
      end

`ifdef PAD_SEQ_SAFE_CFG_EN
      case (state_q)
        ST_WAIT1: begin
          if (cnt_q == 8'd0) begin
            pad_config_q <= cfg_pend_q;
            cnt_q        <= SETTLE_M1;
            state_q      <= ST_WAIT2;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_WAIT2: begin
          if (cnt_q == 8'd0) begin
            pad_dir_q <= dir_saved_q;
            done_q    <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
`endif
    end
  end

  assign pad_out    = pad_out_q;
  assign pad_dir    = pad_dir_q;
  assign pad_config = pad_config_q;
  assign in_sync    = in_sync_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pad_seq_ctrl.sv
// Testbench for pad_seq_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a timeline-based reference model.
module tb_pad_seq_ctrl;

  localparam int S = 4;
`ifdef PAD_SEQ_SAFE_CFG_EN
  localparam bit SAFE = 1'b1;
`else
  localparam bit SAFE = 1'b0;
`endif

  localparam logic [1:0] OP_OUT = 2'd0;
  localparam logic [1:0] OP_DIR = 2'd1;
  localparam logic [1:0] OP_CFG = 2'd2;
  localparam logic [1:0] OP_SMP = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [17:0] cmd_data = '0;
  logic        done;
  logic        busy;
  logic [3:0]  pad_in = '0;
  logic [1:0]  pad_out;
  logic [3:0]  pad_dir;
  logic [17:0] pad_config;
  logic [3:0]  in_sync;

  pad_seq_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .done(done), .busy(busy),
    .pad_in(pad_in), .pad_out(pad_out), .pad_dir(pad_dir),
    .pad_config(pad_config), .in_sync(in_sync)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: expected pad state after each edge. A SET_CFG sequence
  // is described by its accept edge number; events fall at fixed offsets.
  logic [1:0]  m_out = '0;
  logic [3:0]  m_dir = '0;
  logic [3:0]  m_saved = '0;
  logic [3:0]  m_in = '0;
  logic [17:0] m_cfg = '0;
  logic [17:0] m_pend = '0;
  bit          m_done = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_acc = 1'b0;
  int          m_t0 = 0;
  int          cyc = 0;
  logic [3:0]  hist[$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_all();
    check_val("pad_out",    32'(pad_out),    32'(m_out));
    check_val("pad_dir",    32'(pad_dir),    32'(m_dir));
    check_val("pad_config", 32'(pad_config), 32'(m_cfg));
    check_val("in_sync",    32'(in_sync),    32'(m_in));
    check_val("done",       32'(done),       32'(m_done));
    check_val("busy",       32'(busy),       32'(m_busy));
    check_val("cmd_ready",  32'(cmd_ready),  32'(!m_busy));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [17:0] d, input logic [3:0] pin);
    logic [3:0] synced;
    int         elapsed;
    rst = r; cmd_valid = v; cmd_op = op; cmd_data = d; pad_in = pin;
    m_acc = !r && v && !m_busy;
    cyc++;
    if (r) begin
      m_out = '0; m_dir = '0; m_saved = '0; m_in = '0; m_cfg = '0;
      m_done = 1'b0; m_busy = 1'b0;
      hist.delete();
    end else begin
      m_done = 1'b0;
      // pad_in value seen by the synchronizer output: sampled two edges ago.
      synced = (hist.size() >= 2) ? hist[hist.size()-2] : 4'h0;
      hist.push_back(pin);
      if (hist.size() > 4) void'(hist.pop_front());
      if (m_busy) begin
        elapsed = cyc - m_t0;
        if (elapsed == S) m_cfg = m_pend;
        if (elapsed == 2*S) begin
          m_dir = m_saved; m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (m_acc) begin
        case (op)
          OP_OUT: begin m_out = d[1:0]; m_done = 1'b1; end
          OP_DIR: begin m_dir = d[3:0]; m_saved = d[3:0]; m_done = 1'b1; end
          OP_CFG: begin
            if (SAFE) begin
              m_pend = d; m_dir = '0; m_busy = 1'b1; m_t0 = cyc;
            end else begin
              m_cfg = d; m_done = 1'b1;
            end
          end
          default: begin m_in = synced; m_done = 1'b1; end
        endcase
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic [3:0] pin);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, OP_OUT, '0, pin);
  endtask

  initial begin
    int  low_cnt, nready_cnt, cfg_at, done_at, waits;
    bit  got, saw_done;

    // Reset held two cycles with random inputs.
    for (int k = 0; k < 2; k++)
      step(1'b1, 1'(($urandom)), 2'($urandom), 18'($urandom), 4'($urandom));
    idle(1, 4'h5);
    check_val("rst_ready", 32'(cmd_ready), 32'd1);

    // Back-to-back simple ops; pad_in=5 already stable for several edges.
    idle(2, 4'h5);
    step(1'b0, 1'b1, OP_DIR, 18'hA, 4'h5);
    check_val("plan_done1", 32'(done), 32'd1);
    step(1'b0, 1'b1, OP_OUT, 18'h3, 4'h5);
    check_val("plan_done2", 32'(done), 32'd1);
    step(1'b0, 1'b1, OP_SMP, 18'h0, 4'h5);
    check_val("plan_done3", 32'(done), 32'd1);
    check_val("plan_dir",  32'(pad_dir), 32'hA);
    check_val("plan_out",  32'(pad_out), 32'h3);
    check_val("plan_insync", 32'(in_sync), 32'h5);

    // Config sequence timing with dir=0xF.
    step(1'b0, 1'b1, OP_DIR, 18'hF, 4'h0);
    low_cnt = 0; nready_cnt = 0; cfg_at = -1; done_at = -1;
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) step(1'b0, 1'b1, OP_CFG, 18'h2AAAA, 4'h0);
      else        idle(1, 4'h0);
      if (pad_dir == 4'h0) low_cnt++;
      if (!cmd_ready) nready_cnt++;
      if (cfg_at < 0 && pad_config == 18'h2AAAA) cfg_at = k;
      if (done_at < 0 && done) done_at = k;
    end
    check_val("cfg_dir_low",   32'(low_cnt),    SAFE ? 32'(2*S) : 32'd0);
    check_val("cfg_not_ready", 32'(nready_cnt), SAFE ? 32'(2*S) : 32'd0);
    check_val("cfg_apply_at",  32'(cfg_at),     SAFE ? 32'(S)   : 32'd0);
    check_val("cfg_done_at",   32'(done_at),    SAFE ? 32'(2*S) : 32'd0);
    check_val("cfg_dir_back",  32'(pad_dir),    32'hF);

    // Backpressure: SET_OUT held valid behind a SET_CFG.
    step(1'b0, 1'b1, OP_OUT, 18'h0, 4'h0);
    step(1'b0, 1'b1, OP_CFG, 18'h15555, 4'h0);
    got = 1'b0; waits = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step(1'b0, 1'b1, OP_OUT, 18'h1, 4'h0);
      waits++;
      got = (pad_out == 2'd1);
    end
    check_val("bp_accepted", 32'(got), 32'd1);
    check_val("bp_wait", 32'(waits), SAFE ? 32'(2*S+1) : 32'd1);
    idle(2, 4'h0);

    // Reset two cycles into a SET_CFG.
    step(1'b0, 1'b1, OP_CFG, 18'h12345, 4'h0);
    saw_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle(1, 4'h0);
      saw_done |= done;
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, OP_CFG, 18'h3FFFF, 4'h0);
      saw_done |= done;
    end
    for (int k = 0; k < 10; k++) begin
      idle(1, 4'h0);
      saw_done |= done;
    end
    check_val("mid_rst_cfg",   32'(pad_config), 32'd0);
    check_val("mid_rst_dir",   32'(pad_dir),    32'd0);
    check_val("mid_rst_done",  32'(saw_done),   32'd0);
    check_val("mid_rst_ready", 32'(cmd_ready),  32'd1);

    // SET_CFG with dir=0x6: immediate in the plain build.
    step(1'b0, 1'b1, OP_DIR, 18'h6, 4'h0);
    step(1'b0, 1'b1, OP_CFG, 18'h3FFFF, 4'h0);
    check_val("plain_cfg",  32'(pad_config), SAFE ? 32'd0 : 32'h3FFFF);
    check_val("plain_dir",  32'(pad_dir),    SAFE ? 32'd0 : 32'h6);
    check_val("plain_busy", 32'(busy),       SAFE ? 32'd1 : 32'd0);
    idle(2*S + 2, 4'h0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 9) < 7),
           2'($urandom), 18'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
